// File: rtl/adaptive_filter_input_join.sv
`timescale 1ns/1ps
// adaptive_filter_input_join
// Joins the main (signal) and aux (reference) AXIS streams beat-by-beat into
// one paired stream {aux, main}. Packet boundaries and sideband follow the main
// port. When the two ports disagree on packet length, the short side is padded
// with zeros (aux short) or the surplus aux beats are drained (aux long), and
// each such event bumps a saturating misalignment counter.
//
// Handshake: every port follows AXIS valid/ready. A beat transfers on a rising
// edge where tvalid && tready. Sources never drop tvalid or change payload
// while waiting. m_axis_* is a single register stage that holds its payload
// while m_axis_tvalid && !m_axis_tready.
module adaptive_filter_input_join #(
  parameter int ITEM_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic                  axis_data_clk,
  input  logic                  axis_data_rst,
  input  logic                  cfg_aux_en,
  input  logic                  err_clear,
  output logic [ERR_W-1:0]      err_count,
  input  logic [ITEM_W-1:0]     s_main_axis_tdata,
  input  logic                  s_main_axis_tlast,
  input  logic                  s_main_axis_tvalid,
  output logic                  s_main_axis_tready,
  input  logic [63:0]           s_main_axis_ttimestamp,
  input  logic                  s_main_axis_thas_time,
  input  logic [15:0]           s_main_axis_tlength,
  input  logic                  s_main_axis_teov,
  input  logic                  s_main_axis_teob,
  input  logic [ITEM_W-1:0]     s_aux_axis_tdata,
  input  logic                  s_aux_axis_tlast,
  input  logic                  s_aux_axis_tvalid,
  output logic                  s_aux_axis_tready,
  output logic [2*ITEM_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [63:0]           m_axis_ttimestamp,
  output logic                  m_axis_thas_time,
  output logic [15:0]           m_axis_tlength,
  output logic                  m_axis_teov,
  output logic                  m_axis_teob,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_PAIR      = 2'd0,
    ST_PAD       = 2'd1,
    ST_DRAIN_AUX = 2'd2,
    ST_BYPASS    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               first_q, first_d;
  logic               aux_en_q, aux_en_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               load;
  logic               pair_mode;
  logic               main_rdy;
  logic               aux_rdy;
  logic               main_hs;
  logic               err_inc;
  logic [ITEM_W-1:0]  aux_part;

  // The output register may accept a new beat when empty or being drained.
  assign load = !m_axis_tvalid || m_axis_tready;

  // At a packet start the live config decides the mode; mid-packet the latch does.
  assign pair_mode = first_q ? cfg_aux_en : aux_en_q;

  // Neither input port is ever ready while reset is held.
  assign s_main_axis_tready = main_rdy && !axis_data_rst;
  assign s_aux_axis_tready  = aux_rdy  && !axis_data_rst;

  assign err_count = err_q;
  assign dbg_state = state_q;

  // Next-state, port readiness, aux payload selection and counter update.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    aux_en_d = aux_en_q;
    err_d    = err_q;
    main_rdy = 1'b0;
    aux_rdy  = 1'b0;
    aux_part = '0;
    err_inc  = 1'b0;
    main_hs  = 1'b0;

    case (state_q)
      ST_PAIR: begin
        if (pair_mode) begin
          // Both ports move together or not at all.
          main_rdy = load && s_main_axis_tvalid && s_aux_axis_tvalid;
          aux_rdy  = main_rdy;
          aux_part = s_aux_axis_tdata;
          if (main_rdy) begin
            if (s_main_axis_tlast && !s_aux_axis_tlast) begin
              state_d = ST_DRAIN_AUX;
              err_inc = 1'b1;
            end else if (!s_main_axis_tlast && s_aux_axis_tlast) begin
              state_d = ST_PAD;
              err_inc = 1'b1;
            end
          end
        end else begin
          // Packet starts unpaired: aux is discarded for the whole packet.
          main_rdy = load;
          aux_rdy  = 1'b1;
          if (load && s_main_axis_tvalid && !s_main_axis_tlast) begin
            state_d = ST_BYPASS;
          end
        end
      end
      ST_PAD: begin
        main_rdy = load;
        if (load && s_main_axis_tvalid && s_main_axis_tlast) begin
          state_d = ST_PAIR;
        end
      end
      ST_DRAIN_AUX: begin
        aux_rdy = 1'b1;
        if (s_aux_axis_tvalid && s_aux_axis_tlast) begin
          state_d = ST_PAIR;
        end
      end
      ST_BYPASS: begin
        main_rdy = load;
        aux_rdy  = 1'b1;
        if (load && s_main_axis_tvalid && s_main_axis_tlast) begin
          state_d = ST_PAIR;
        end
      end
      default: state_d = ST_PAIR;
    endcase

    main_hs = main_rdy && s_main_axis_tvalid;

    // Packet-start tracking follows accepted main beats only.
    if (main_hs) begin
      first_d = s_main_axis_tlast;
      if (first_q) begin
        aux_en_d = cfg_aux_en;
      end
    end

    // A clear wins over a same-cycle event; the count sticks at all-ones.
    if (err_clear) begin
      err_d = '0;
    end else if (err_inc && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      state_q  <= ST_PAIR;
      first_q  <= 1'b1;
      aux_en_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      aux_en_q <= aux_en_d;
      err_q    <= err_d;
    end
  end

  // Output register stage; payload only changes when a new main beat lands.
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_ttimestamp <= '0;
      m_axis_thas_time  <= 1'b0;
      m_axis_tlength    <= '0;
      m_axis_teov       <= 1'b0;
      m_axis_teob       <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= main_hs;
      if (main_hs) begin
        m_axis_tdata      <= {aux_part, s_main_axis_tdata};
        m_axis_tlast      <= s_main_axis_tlast;
        m_axis_ttimestamp <= s_main_axis_ttimestamp;
        m_axis_thas_time  <= s_main_axis_thas_time;
        m_axis_tlength    <= s_main_axis_tlength;
        m_axis_teov       <= s_main_axis_teov;
        m_axis_teob       <= s_main_axis_teob;
      end
    end
  end

endmodule

// File: tb/tb_adaptive_filter_input_join.sv
`timescale 1ns/1ps
// Bench for adaptive_filter_input_join: packet-level model of pairing, padding,
// draining and bypass, with a per-cycle output compare process.
module tb_adaptive_filter_input_join;

  localparam int W   = 32;
  localparam int EW  = 8;
  localparam int TMO = 300;

  typedef struct packed {
    logic [2*W-1:0] data;
    logic           last;
    logic [63:0]    ts;
    logic           has_time;
    logic [15:0]    len;
    logic           eov;
    logic           eob;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           cfg_aux_en;
  logic           err_clear;
  logic [EW-1:0]  err_count;
  logic [W-1:0]   s_main_axis_tdata;
  logic           s_main_axis_tlast;
  logic           s_main_axis_tvalid;
  logic           s_main_axis_tready;
  logic [63:0]    s_main_axis_ttimestamp;
  logic           s_main_axis_thas_time;
  logic [15:0]    s_main_axis_tlength;
  logic           s_main_axis_teov;
  logic           s_main_axis_teob;
  logic [W-1:0]   s_aux_axis_tdata;
  logic           s_aux_axis_tlast;
  logic           s_aux_axis_tvalid;
  logic           s_aux_axis_tready;
  logic [2*W-1:0] m_axis_tdata;
  logic           m_axis_tlast;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [63:0]    m_axis_ttimestamp;
  logic           m_axis_thas_time;
  logic [15:0]    m_axis_tlength;
  logic           m_axis_teov;
  logic           m_axis_teob;
  logic [1:0]     dbg_state;

  adaptive_filter_input_join #(.ITEM_W(W), .ERR_W(EW)) dut (
    .axis_data_clk          (clk),
    .axis_data_rst          (rst),
    .cfg_aux_en             (cfg_aux_en),
    .err_clear              (err_clear),
    .err_count              (err_count),
    .s_main_axis_tdata      (s_main_axis_tdata),
    .s_main_axis_tlast      (s_main_axis_tlast),
    .s_main_axis_tvalid     (s_main_axis_tvalid),
    .s_main_axis_tready     (s_main_axis_tready),
    .s_main_axis_ttimestamp (s_main_axis_ttimestamp),
    .s_main_axis_thas_time  (s_main_axis_thas_time),
    .s_main_axis_tlength    (s_main_axis_tlength),
    .s_main_axis_teov       (s_main_axis_teov),
    .s_main_axis_teob       (s_main_axis_teob),
    .s_aux_axis_tdata       (s_aux_axis_tdata),
    .s_aux_axis_tlast       (s_aux_axis_tlast),
    .s_aux_axis_tvalid      (s_aux_axis_tvalid),
    .s_aux_axis_tready      (s_aux_axis_tready),
    .m_axis_tdata           (m_axis_tdata),
    .m_axis_tlast           (m_axis_tlast),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_ttimestamp      (m_axis_ttimestamp),
    .m_axis_thas_time       (m_axis_thas_time),
    .m_axis_tlength         (m_axis_tlength),
    .m_axis_teov            (m_axis_teov),
    .m_axis_teob            (m_axis_teob),
    .dbg_state              (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  beat_t          exp_q[$];
  logic [2*W-1:0] obs_q[$];
  int             n_assert = 0;
  int             n_fail   = 0;
  int             err_m    = 0;
  int             gap_max  = 0;
  int             rdy_pct  = 50;
  bit             chk_en   = 1'b0;
  bit             force_rdy = 1'b1;

  logic [W-1:0]   pm_data[$];
  logic [63:0]    pm_ts[$];
  logic           pm_ht[$];
  logic [15:0]    pm_len[$];
  logic           pm_eov[$];
  logic           pm_eob[$];
  logic [W-1:0]   pa_data[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: actual timeout expected handshake", name);
  endtask

  // Output sink readiness, changed just after each rising edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = force_rdy ? 1'b1 : ($urandom_range(0, 99) < 32'(rdy_pct));
    end
  end

  // Compare process: every accepted output beat against the model, and hold
  // stability across stalls.
  beat_t cur_b, prev_b, e_b;
  bit    stall_prev = 1'b0;
  always @(negedge clk) begin
    cur_b = {m_axis_tdata, m_axis_tlast, m_axis_ttimestamp, m_axis_thas_time,
             m_axis_tlength, m_axis_teov, m_axis_teob};
    if (chk_en && !rst) begin
      if (stall_prev) begin
        chk("stall_valid", 160'(m_axis_tvalid), 160'(1));
        chk("stall_hold", 160'(cur_b), 160'(prev_b));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back(m_axis_tdata);
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_beat: actual %0h expected none", m_axis_tdata);
        end else begin
          e_b = exp_q.pop_front();
          chk("out_beat", 160'(cur_b), 160'(e_b));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
    end else begin
      stall_prev = 1'b0;
    end
    prev_b = cur_b;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_main(input bit toggle, input bit clr_first);
    int n;
    int g;
    int t;
    bit hs;
    n = pm_data.size();
    for (int i = 0; i < n; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      s_main_axis_tvalid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      s_main_axis_tdata      = pm_data[i];
      s_main_axis_ttimestamp = pm_ts[i];
      s_main_axis_thas_time  = pm_ht[i];
      s_main_axis_tlength    = pm_len[i];
      s_main_axis_teov       = pm_eov[i];
      s_main_axis_teob       = pm_eob[i];
      s_main_axis_tlast      = (i == n - 1);
      s_main_axis_tvalid     = 1'b1;
      if (clr_first && i == 0) err_clear = 1'b1;
      hs = 1'b0;
      t  = 0;
      while (!hs && t < TMO) begin
        @(negedge clk);
        hs = s_main_axis_tready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) fail_now("main_timeout");
      err_clear = 1'b0;
      if (toggle && i == 0) cfg_aux_en = !cfg_aux_en;
    end
    s_main_axis_tvalid = 1'b0;
    s_main_axis_tlast  = 1'b0;
  endtask

  task automatic drive_aux(input bit bypass, input int gmax);
    int n;
    int g;
    int t;
    bit hs;
    n = pa_data.size();
    for (int i = 0; i < n; i++) begin
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      s_aux_axis_tvalid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      s_aux_axis_tdata  = pa_data[i];
      s_aux_axis_tlast  = (i == n - 1);
      s_aux_axis_tvalid = 1'b1;
      hs = 1'b0;
      t  = 0;
      while (!hs && t < TMO) begin
        @(negedge clk);
        hs = s_aux_axis_tready;
        if (bypass && t == 0) chk("aux_ready_bypass", 160'(hs), 160'(1));
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) fail_now("aux_timeout");
    end
    s_aux_axis_tvalid = 1'b0;
    s_aux_axis_tlast  = 1'b0;
  endtask

  // One main packet of lm beats alongside an aux packet of la beats.
  // mode=1 pairs them; mode=0 discards aux and zero-pads.
  task automatic run_pkt(input int lm, input int la, input bit mode, input bit seq,
                         input bit toggle, input bit clr);
    beat_t        b;
    logic [W-1:0] hi;
    pm_data.delete(); pm_ts.delete(); pm_ht.delete();
    pm_len.delete(); pm_eov.delete(); pm_eob.delete(); pa_data.delete();
    for (int i = 0; i < lm; i++) begin
      pm_data.push_back(seq ? W'(i + 1) : W'($urandom()));
      pm_ts.push_back({$urandom(), $urandom()});
      pm_ht.push_back(1'($urandom_range(0, 1)));
      pm_len.push_back(16'($urandom_range(0, 65535)));
      pm_eov.push_back(1'($urandom_range(0, 1)));
      pm_eob.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < la; i++) begin
      pa_data.push_back(seq ? W'(32'hA + i) : W'($urandom()));
    end
    // Reference: main length rules; aux fills the upper half while it lasts.
    for (int i = 0; i < lm; i++) begin
      hi = (mode && i < la) ? pa_data[i] : W'(0);
      b.data     = {hi, pm_data[i]};
      b.last     = (i == lm - 1);
      b.ts       = pm_ts[i];
      b.has_time = pm_ht[i];
      b.len      = pm_len[i];
      b.eov      = pm_eov[i];
      b.eob      = pm_eob[i];
      exp_q.push_back(b);
    end
    if (clr) err_m = 0;
    else if (mode && lm != la && err_m < (2 ** EW) - 1) err_m = err_m + 1;
    cfg_aux_en = mode;
    fork
      drive_main(toggle, clr);
      if (la > 0) drive_aux(!mode, toggle ? 0 : gap_max);
    join
    chk("err_count", 160'(err_count), 160'(err_m));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 160'(exp_q.size()), 160'(0));
  endtask

  // ---------------- main sequence ----------------
  logic [2*W-1:0] t1_exp[4];
  beat_t          bt;
  int             beats;
  int             lm, la;
  bit             md, tg;

  initial begin
    t1_exp[0] = 64'h0000000A_00000001;
    t1_exp[1] = 64'h0000000B_00000002;
    t1_exp[2] = 64'h0000000C_00000003;
    t1_exp[3] = 64'h0000000D_00000004;

    rst = 1'b1; cfg_aux_en = 1'b1; err_clear = 1'b0;
    s_main_axis_tdata = '0; s_main_axis_tlast = 1'b0; s_main_axis_tvalid = 1'b1;
    s_main_axis_ttimestamp = '0; s_main_axis_thas_time = 1'b0; s_main_axis_tlength = '0;
    s_main_axis_teov = 1'b0; s_main_axis_teob = 1'b0;
    s_aux_axis_tdata = '0; s_aux_axis_tlast = 1'b0; s_aux_axis_tvalid = 1'b1;

    // Reset state, with both sources offering data.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 160'(m_axis_tvalid), 160'(0));
    chk("rst_m_tdata", 160'(m_axis_tdata), 160'(0));
    chk("rst_err", 160'(err_count), 160'(0));
    chk("rst_main_ready", 160'(s_main_axis_tready), 160'(0));
    chk("rst_aux_ready", 160'(s_aux_axis_tready), 160'(0));
    @(posedge clk); #1;
    s_main_axis_tvalid = 1'b0; s_aux_axis_tvalid = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Aligned 4/4 packet at full rate; output one cycle behind input.
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        s_main_axis_tdata = W'(k + 1); s_aux_axis_tdata = W'(32'hA + k);
        s_main_axis_tlast = (k == 3); s_aux_axis_tlast = (k == 3);
        s_main_axis_ttimestamp = 64'(k); s_main_axis_thas_time = 1'b1;
        s_main_axis_tlength = 16'd4; s_main_axis_teov = 1'b0; s_main_axis_teob = (k == 3);
        s_main_axis_tvalid = 1'b1; s_aux_axis_tvalid = 1'b1;
        bt = {t1_exp[k], (k == 3), 64'(k), 1'b1, 16'd4, 1'b0, (k == 3)};
        exp_q.push_back(bt);
      end else begin
        s_main_axis_tvalid = 1'b0; s_aux_axis_tvalid = 1'b0;
        s_main_axis_tlast = 1'b0; s_aux_axis_tlast = 1'b0;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("t1_latency_idle", 160'(m_axis_tvalid), 160'(0));
      end else begin
        chk("t1_valid", 160'(m_axis_tvalid), 160'(1));
        chk("t1_data", 160'(m_axis_tdata), 160'(t1_exp[k - 1]));
        chk("t1_last", 160'(m_axis_tlast), 160'(k == 4));
      end
      @(posedge clk); #1;
    end
    wait_drain();
    chk("t1_err", 160'(err_count), 160'(0));

    // Aux short: last two beats zero-padded.
    force_rdy = 1'b0; rdy_pct = 50; gap_max = 1;
    obs_q.delete();
    run_pkt(4, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("t2_count", 160'(obs_q.size()), 160'(4));
    chk("t2_beat1", 160'(obs_q[0]), 160'(64'h0000000A_00000001));
    chk("t2_beat3", 160'(obs_q[2]), 160'(64'h00000000_00000003));
    chk("t2_beat4", 160'(obs_q[3]), 160'(64'h00000000_00000004));
    chk("t2_err", 160'(err_count), 160'(1));
    run_pkt(3, 3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Aux long: surplus aux beats vanish.
    wait_drain();
    obs_q.delete();
    run_pkt(2, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("t3_count", 160'(obs_q.size()), 160'(2));
    chk("t3_beat2", 160'(obs_q[1]), 160'(64'h0000000B_00000002));
    chk("t3_err", 160'(err_count), 160'(2));
    run_pkt(4, 4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bypass with aux traffic; cfg flips mid-packet.
    wait_drain();
    obs_q.delete();
    run_pkt(4, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain();
    chk("t4_beat1", 160'(obs_q[0]), 160'(64'h00000000_00000001));
    chk("t4_beat4", 160'(obs_q[3]), 160'(64'h00000000_00000004));
    run_pkt(3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pkt(3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_err", 160'(err_count), 160'(2));

    // Randomized traffic.
    beats = 0;
    while (beats < 1000) begin
      lm = int'($urandom_range(1, 8));
      md = ($urandom_range(0, 3) != 0);
      if (md) la = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : lm;
      else    la = int'($urandom_range(0, 2));
      tg = (lm >= 2) && ($urandom_range(0, 3) == 0);
      gap_max = int'($urandom_range(0, 2));
      run_pkt(lm, la, md, 1'b0, tg, 1'b0);
      beats += lm;
    end
    wait_drain();

    // Clear coinciding with a mismatch event.
    force_rdy = 1'b1; gap_max = 0;
    @(posedge clk); #1;
    run_pkt(2, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_clear_wins", 160'(err_count), 160'(0));

    // Saturation.
    force_rdy = 1'b0;
    for (int i = 0; i < 300; i++) run_pkt(1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_saturated", 160'(err_count), 160'((2 ** EW) - 1));
    wait_drain();

    // Reset in the middle of a packet.
    force_rdy = 1'b1;
    chk_en = 1'b0;
    cfg_aux_en = 1'b1;
    @(posedge clk); #1;
    s_main_axis_tdata = 32'h55; s_aux_axis_tdata = 32'h66;
    s_main_axis_tlast = 1'b0; s_aux_axis_tlast = 1'b0;
    s_main_axis_tvalid = 1'b1; s_aux_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_main_ready", 160'(s_main_axis_tready), 160'(0));
    chk("t6_rst_aux_ready", 160'(s_aux_axis_tready), 160'(0));
    @(posedge clk); #1;
    chk("t6_rst_tvalid", 160'(m_axis_tvalid), 160'(0));
    chk("t6_rst_err", 160'(err_count), 160'(0));
    chk("t6_rst_tdata", 160'(m_axis_tdata), 160'(0));
    s_main_axis_tvalid = 1'b0; s_aux_axis_tvalid = 1'b0;
    rst = 1'b0;
    err_m = 0;
    exp_q.delete();
    chk_en = 1'b1;
    @(posedge clk); #1;
    force_rdy = 1'b0;
    run_pkt(3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time limit.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual still running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule
